// File: rtl/ama_riscv_imem_responder.sv
// ama_riscv_imem_responder
//   Responder side of the instruction-fetch ready/valid channel. Each accepted
//   request travels a LATENCY-stage pipe. The instruction array is read at the
//   last stage, and the word lands in a first-word-fall-through response FIFO.
//   Credits (pipe valids + FIFO count) guarantee a FIFO slot for every accepted
//   request, so the pipe never stalls.
// Ports
//   clk, rst                      clock, async active-high reset
//   req_valid/req_ready/req_addr  fetch request (byte address, [1:0] ignored)
//   rsp_valid/rsp_ready/rsp_data  instruction response
//   flush                         drop everything in flight or buffered
//   ld_we/ld_addr/ld_wdata        preload write port (byte address)
//   busy                          in-flight or buffered responses exist
module ama_riscv_imem_responder #(
  parameter int MEM_WORDS = 16384,
  parameter int LATENCY   = 2,
  parameter int RSP_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  input  logic        flush,
  input  logic        ld_we,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_wdata,
  output logic        busy
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int NR = (LATENCY > 1) ? LATENCY - 1 : 1;  // registered pipe stages
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = $clog2(RSP_DEPTH);
  localparam int OW = $clog2(LATENCY + RSP_DEPTH + 1);

  logic [31:0]                 mem [MEM_WORDS];
  logic [31:0]                 fifo [RSP_DEPTH];
  logic [NR-1:0]               vld_r;
  logic [NR-1:0][AW-1:0]       idx_r;
  logic [LATENCY-1:0]          vld_pipe;
  logic [LATENCY-1:0][AW-1:0]  idx_pipe;
  logic [PW-1:0]               wr_ptr, rd_ptr;
  logic [CW-1:0]               cnt;
  logic [31:0]                 last_data;
  logic                        rdy_en;
  logic [OW-1:0]               occ;
  logic                        acc, push, pop;
  logic [31:0]                 rd_word;
  logic                        unused_bits;

  assign unused_bits = ^{req_addr[31:AW+2], req_addr[1:0], ld_addr[31:AW+2], ld_addr[1:0]};

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Stage 0 is the request being accepted this cycle; stages 1.. are registered.
  always_comb begin
    vld_pipe    = '0;
    idx_pipe    = '0;
    vld_pipe[0] = acc;
    idx_pipe[0] = req_addr[AW+1:2];
    for (int i = 1; i < LATENCY; i++) begin
      vld_pipe[i] = vld_r[i-1];
      idx_pipe[i] = idx_r[i-1];
    end
  end

  always_comb begin
    occ = OW'(cnt);
    for (int i = 0; i < NR; i++) occ = occ + OW'(vld_r[i]);
  end

  // rdy_en keeps req_ready low until the first edge after reset release.
  assign req_ready = rdy_en && (occ < OW'(RSP_DEPTH));
  assign acc       = req_valid && req_ready;
  assign rd_word   = mem[idx_pipe[LATENCY-1]];
  assign push      = vld_pipe[LATENCY-1] && !flush;
  assign rsp_valid = (cnt != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_data  = rsp_valid ? fifo[rd_ptr] : last_data;
  assign busy      = (occ != '0);

  always_ff @(posedge clk) begin
    if (ld_we) mem[ld_addr[AW+1:2]] <= ld_wdata;
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= rd_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_r     <= '0;
      idx_r     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      last_data <= '0;
      rdy_en    <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      for (int i = 0; i < LATENCY - 1; i++) begin
        vld_r[i] <= vld_pipe[i] && !flush;
        idx_r[i] <= idx_pipe[i];
      end
      // rsp_data keeps showing the last consumed word once the FIFO empties.
      if (pop) last_data <= fifo[rd_ptr];
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push) wr_ptr <= ptr_inc(wr_ptr);
        if (pop)  rd_ptr <= ptr_inc(rd_ptr);
        cnt <= cnt + CW'(push) - CW'(pop);
      end
    end
  end

  // Credits make a push into a full FIFO without a pop impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && cnt == CW'(RSP_DEPTH)));

endmodule
